// File: rtl/mem_stage_lsu_if.sv
// Single-outstanding valid/ready data bus between the memory-stage LSU and the data memory.
interface mem_stage_lsu_if #(
  parameter int XLEN = 32
);
  logic                bus_req_valid;
  logic                bus_req_ready;
  logic [XLEN-1:0]     bus_addr;
  logic                bus_we;
  logic [XLEN-1:0]     bus_wdata;
  logic [XLEN/8-1:0]   bus_wstrb;
  logic                bus_resp_valid;
  logic [XLEN-1:0]     bus_rdata;

  modport master (
    output bus_req_valid, bus_addr, bus_we, bus_wdata, bus_wstrb,
    input  bus_req_ready, bus_resp_valid, bus_rdata
  );

  modport slave (
    input  bus_req_valid, bus_addr, bus_we, bus_wdata, bus_wstrb,
    output bus_req_ready, bus_resp_valid, bus_rdata
  );
endinterface

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: one bus transaction at a time, lane-aligned stores,
// sign/zero-extended loads, misalignment flagged instead of issued.
module mem_stage_lsu #(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [2:0]        funct3,
  input  logic [XLEN-1:0]   addr,
  input  logic [XLEN-1:0]   wdata,
  input  logic              flush,
  mem_stage_lsu_if.master   bus,
  output logic              hold,
  output logic              done,
  output logic [XLEN-1:0]   load_data,
  output logic              load_misaligned,
  output logic              store_misaligned,
  output logic [XLEN-1:0]   fault_addr
);

  localparam int STRBW = XLEN / 8;
  localparam int OFFW  = $clog2(STRBW);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]        state_q,  state_d;
  logic [OFFW-1:0]   off_q,    off_d;
  logic [2:0]        f3_q,     f3_d;
  logic              we_q,     we_d;
  logic              kill_q,   kill_d;
  logic [XLEN-1:0]   baddr_q,  baddr_d;
  logic [XLEN-1:0]   bwdata_q, bwdata_d;
  logic [STRBW-1:0]  bstrb_q,  bstrb_d;
  logic [XLEN-1:0]   ld_q,     ld_d;

  logic [OFFW-1:0]   off;
  logic              is_req;
  logic              misal;
  logic              accept;

  // An access of 2^sz bytes needs its low sz offset bits clear.
  function automatic logic misaligned_f(input logic [1:0] sz, input logic [OFFW-1:0] o);
    logic [OFFW-1:0] m;
    m = '0;
    for (int i = 0; i < OFFW; i++) m[i] = (i < int'(sz));
    return |(o & m);
  endfunction

  function automatic logic [STRBW-1:0] strb_f(input logic [1:0] sz, input logic [OFFW-1:0] o);
    logic [STRBW-1:0] m;
    m = '0;
    for (int i = 0; i < STRBW; i++) m[i] = (i < (1 << int'(sz)));
    return m << o;
  endfunction

  function automatic logic [XLEN-1:0] ext_load_f(input logic [2:0] f3, input logic [XLEN-1:0] sh);
    logic [XLEN-1:0] res;
    logic            sgn;
    int              w;
    w   = 8 << int'(f3[1:0]);
    if (w > XLEN) w = XLEN;
    sgn = ~f3[2] & (f3[1:0] != 2'd3) & sh[w-1];
    res = '0;
    for (int i = 0; i < XLEN; i++) res[i] = (i < w) ? sh[i] : sgn;
    return res;
  endfunction

  assign off    = addr[OFFW-1:0];
  assign is_req = (state_q == S_IDLE) && req_valid && !flush;
  assign misal  = misaligned_f(funct3[1:0], off);
  assign accept = is_req && !misal;

  assign load_misaligned  = is_req && misal && mem_read;
  assign store_misaligned = is_req && misal && mem_write;
  assign fault_addr       = addr;

  assign hold = accept || (state_q == S_REQ) || (state_q == S_WAIT);
  // A flush landing in the DONE cycle itself must also squash the completion.
  assign done = (state_q == S_DONE) && !kill_q && !flush;

  assign bus.bus_req_valid = (state_q == S_REQ);
  assign bus.bus_addr      = baddr_q;
  assign bus.bus_we        = we_q;
  assign bus.bus_wdata     = bwdata_q;
  assign bus.bus_wstrb     = bstrb_q;
  assign load_data         = ld_q;

  always_comb begin
    state_d  = state_q;
    off_d    = off_q;
    f3_d     = f3_q;
    we_d     = we_q;
    kill_d   = kill_q;
    baddr_d  = baddr_q;
    bwdata_d = bwdata_q;
    bstrb_d  = bstrb_q;
    ld_d     = ld_q;
    case (state_q)
      S_IDLE: begin
        kill_d = 1'b0;
        if (accept) begin
          state_d  = S_REQ;
          off_d    = off;
          f3_d     = funct3;
          we_d     = mem_write;
          baddr_d  = {addr[XLEN-1:OFFW], {OFFW{1'b0}}};
          bwdata_d = wdata << {off, 3'b000};
          bstrb_d  = mem_write ? strb_f(funct3[1:0], off) : '0;
        end
      end
      S_REQ: begin
        if (flush) kill_d = 1'b1;
        if (bus.bus_req_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (flush) kill_d = 1'b1;
        if (bus.bus_resp_valid) begin
          state_d = S_DONE;
          ld_d    = we_q ? '0 : ext_load_f(f3_q, bus.bus_rdata >> {off_q, 3'b000});
        end
      end
      default: begin
        state_d = S_IDLE;
        kill_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      off_q    <= '0;
      f3_q     <= '0;
      we_q     <= 1'b0;
      kill_q   <= 1'b0;
      baddr_q  <= '0;
      bwdata_q <= '0;
      bstrb_q  <= '0;
      ld_q     <= '0;
    end else begin
      state_q  <= state_d;
      off_q    <= off_d;
      f3_q     <= f3_d;
      we_q     <= we_d;
      kill_q   <= kill_d;
      baddr_q  <= baddr_d;
      bwdata_q <= bwdata_d;
      bstrb_q  <= bstrb_d;
      ld_q     <= ld_d;
    end
  end

endmodule
